mesh_ni_packetizer: RTL

//  Terminal-side network interface for the 2D mesh wormhole XY NoC.
//  - Accepts a message header (destination row/col, payload length) plus a stream of payload words.
//  - Emits a HEAD/BODY/TAIL flit sequence on one terminal input channel of the mesh (ich_data/vld/rdy).
//  - One instance per mesh node; sits directly upstream of the node's TERM input port.

---
 rtl/mesh_ni_packetizer_pkg.sv | 25 ++
 rtl/mesh_ni_packetizer_if.sv | 42 ++++
 rtl/mesh_ni_packetizer_flit_out_reg.sv | 45 ++++
 rtl/mesh_ni_packetizer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mesh_ni_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// mesh_ni_packetizer_pkg : shared flit ids and packetizer FSM encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mesh_ni_packetizer_pkg;

  localparam int FLIT_ID_BITS = 2;

  typedef logic [FLIT_ID_BITS-1:0] flit_id_t;

  // 2'b00 is reserved so an idle/cleared flit can never look like traffic
  localparam flit_id_t FLIT_HEAD = 2'b01;
  localparam flit_id_t FLIT_BODY = 2'b10;
  localparam flit_id_t FLIT_TAIL = 2'b11;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_PLD   = 2'd1;
  localparam logic [ST_W-1:0] ST_ZTAIL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mesh_ni_packetizer_if.sv
// ---------------------------------------------------------------------------
// mesh_ni_packetizer_if : header, payload and flit channels of the packetizer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mesh_ni_packetizer_if #(
  parameter int CHANNEL_W  = 8,
  parameter int FLIT_ID_W  = 2,
  parameter int ROW_ADDR_W = 2,
  parameter int COL_ADDR_W = 2,
  parameter int LEN_W      = 4
);
  logic                          hdr_vld_i;
  logic                          hdr_rdy_o;
  logic [ROW_ADDR_W-1:0]         hdr_row_i;
  logic [COL_ADDR_W-1:0]         hdr_col_i;
  logic [LEN_W-1:0]              hdr_len_i;
  logic                          pld_vld_i;
  logic                          pld_rdy_o;
  logic [CHANNEL_W-FLIT_ID_W-1:0] pld_data_i;
  logic [CHANNEL_W-1:0]          flit_data_o;
  logic                          flit_vld_o;
  logic                          flit_rdy_i;
  logic                          busy_o;
  logic                          pkt_sent_o;

  // master = packetizer, slave = message source plus mesh terminal port
  modport master (
    input  hdr_vld_i, hdr_row_i, hdr_col_i, hdr_len_i,
    input  pld_vld_i, pld_data_i, flit_rdy_i,
    output hdr_rdy_o, pld_rdy_o, flit_data_o, flit_vld_o, busy_o, pkt_sent_o
  );

  modport slave (
    output hdr_vld_i, hdr_row_i, hdr_col_i, hdr_len_i,
    output pld_vld_i, pld_data_i, flit_rdy_i,
    input  hdr_rdy_o, pld_rdy_o, flit_data_o, flit_vld_o, busy_o, pkt_sent_o
  );
endinterface

`default_nettype wire

// File: rtl/mesh_ni_packetizer_flit_out_reg.sv
// ---------------------------------------------------------------------------
// mesh_ni_packetizer_flit_out_reg : single-entry valid/ready flit register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mesh_ni_packetizer_flit_out_reg #(
  parameter int CHANNEL_W = 8
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic                 i_load,
  input  wire logic [CHANNEL_W-1:0] i_data,
  input  wire logic                 i_rdy,
  output logic                      o_ld,
  output logic                      o_vld,
  output logic [CHANNEL_W-1:0]      o_data
);

  logic                 r_vld;
  logic [CHANNEL_W-1:0] r_data;
  logic                 w_ld;

  // register may take a new flit when empty or when its current flit leaves
  assign w_ld = !r_vld || i_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (w_ld) begin
      r_vld <= i_load;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_ld   = w_ld;
  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/mesh_ni_packetizer.sv
// ---------------------------------------------------------------------------
// mesh_ni_packetizer : turns header + payload words into HEAD/BODY/TAIL flits
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mesh_ni_packetizer
  import mesh_ni_packetizer_pkg::*;
#(
  parameter int CHANNEL_W  = 8,
  parameter int FLIT_ID_W  = 2,
  parameter int ROW_ADDR_W = 2,
  parameter int COL_ADDR_W = 2,
  parameter int LEN_W      = 4
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  mesh_ni_packetizer_if.master    bus
);

  localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W;

  if (ROW_ADDR_W + COL_ADDR_W > FLIT_DATA_W) begin : g_addr_too_wide
    $error("mesh_ni_packetizer: row+col address does not fit in the head flit");
  end
  if (FLIT_ID_W != FLIT_ID_BITS) begin : g_bad_id_width
    $error("mesh_ni_packetizer: FLIT_ID_W must be 2");
  end

  logic [ST_W-1:0]        r_state;
  logic [ST_W-1:0]        w_state_nxt;
  logic [LEN_W-1:0]       r_cnt;
  logic                   r_pkt_sent;
  logic                   w_ld;
  logic                   w_hdr_rdy;
  logic                   w_pld_rdy;
  logic                   w_load;
  logic [CHANNEL_W-1:0]   w_flit_d;
  logic [FLIT_DATA_W-1:0] w_head_data;
  logic                   w_flit_vld;
  logic [CHANNEL_W-1:0]   w_flit_data;
  logic                   w_hdr_hs;
  logic                   w_pld_hs;

  assign w_hdr_hs = bus.hdr_vld_i && w_hdr_rdy;
  assign w_pld_hs = bus.pld_vld_i && w_pld_rdy;

  always_comb begin
    w_head_data = '0;
    w_head_data[ROW_ADDR_W+COL_ADDR_W-1:0] = {bus.hdr_row_i, bus.hdr_col_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hdr_hs) w_state_nxt = (bus.hdr_len_i != '0) ? ST_PLD : ST_ZTAIL;
      ST_PLD:   if (w_pld_hs && r_cnt == LEN_W'(1)) w_state_nxt = ST_IDLE;
      ST_ZTAIL: if (w_ld) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ready outputs follow the output register's load enable combinationally
  always_comb begin
    w_hdr_rdy = 1'b0;
    w_pld_rdy = 1'b0;
    w_load    = 1'b0;
    w_flit_d  = '0;
    case (r_state)
      ST_IDLE: begin
        w_hdr_rdy = w_ld;
        w_load    = w_hdr_hs;
        w_flit_d  = {FLIT_HEAD, w_head_data};
      end
      ST_PLD: begin
        w_pld_rdy = w_ld;
        w_load    = w_pld_hs;
        w_flit_d  = {(r_cnt > LEN_W'(1)) ? FLIT_BODY : FLIT_TAIL, bus.pld_data_i};
      end
      ST_ZTAIL: begin
        w_load   = w_ld;
        w_flit_d = {FLIT_TAIL, {FLIT_DATA_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && w_hdr_hs) begin
      r_cnt <= bus.hdr_len_i;
    end else if (r_state == ST_PLD && w_pld_hs) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pkt_sent <= 1'b0;
    end else begin
      r_pkt_sent <= w_flit_vld && bus.flit_rdy_i &&
                    (w_flit_data[CHANNEL_W-1 -: FLIT_ID_W] == FLIT_TAIL);
    end
  end

  mesh_ni_packetizer_flit_out_reg #(
    .CHANNEL_W (CHANNEL_W)
  ) u_flit_out_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (w_load),
    .i_data (w_flit_d),
    .i_rdy  (bus.flit_rdy_i),
    .o_ld   (w_ld),
    .o_vld  (w_flit_vld),
    .o_data (w_flit_data)
  );

  assign bus.hdr_rdy_o   = w_hdr_rdy;
  assign bus.pld_rdy_o   = w_pld_rdy;
  assign bus.flit_vld_o  = w_flit_vld;
  assign bus.flit_data_o = w_flit_data;
  assign bus.pkt_sent_o  = r_pkt_sent;
  assign bus.busy_o      = (r_state != ST_IDLE) || w_flit_vld;

endmodule

`default_nettype wire
